// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_pkg
//  Description : Shared sizing constants and the byte type for the data memory
//                and anything that talks to it.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef logic [DATA_W-1:0] byte_t;

endpackage : mem_pkg
`default_nettype wire

// File: rtl/data_memory.sv
`default_nettype none
// ============================================================================
//  Module      : data_memory
//  Description : Byte-addressable data memory for the single-cycle datapath.
//                Clocked write port, combinational read port. Storage is a
//                plain unpacked array (mem_core) so it can be preloaded and
//                inspected hierarchically. Reset gates the ports only; it
//                never clears the array, so preloaded operands survive.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_memory #(
  parameter int DATA_W = mem_pkg::DATA_W,
  parameter int ADDR_W = mem_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] DataAddress,
  input  logic              ReadMem,
  input  logic              WriteMem,
  input  logic [DATA_W-1:0] DataIn,
  output logic [DATA_W-1:0] DataOut
);

  localparam int DEPTH = 1 << ADDR_W;

  // Deliberately left uninitialised: power-up contents are undefined and
  // reset must not touch them.
  logic [DATA_W-1:0] mem_core [0:DEPTH-1];

  // Write port: one entry updated per edge, suppressed while reset is high.
  always_ff @(posedge clk) begin
    if (!reset && WriteMem) begin
      mem_core[DataAddress] <= DataIn;
    end
  end

  // Read port: purely combinational, forced to zero when disabled or in reset.
  always_comb begin
    DataOut = '0;
    if (ReadMem && !reset) begin
      DataOut = mem_core[DataAddress];
    end
  end

endmodule : data_memory
`default_nettype wire

// File: tb/tb_data_memory.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_memory
//  Description : Self-checking bench for data_memory. Stimulus pushes the
//                expected DataOut into a queue and raises obs_valid; a
//                separate monitor pops and compares on the falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_memory;
  import mem_pkg::*;

  typedef struct {
    string name;
    byte_t exp;
  } exp_t;

  logic              clk;
  logic              reset;
  logic [ADDR_W-1:0] DataAddress;
  logic              ReadMem;
  logic              WriteMem;
  byte_t             DataIn;
  byte_t             DataOut;

  logic              obs_valid;
  exp_t              sb_q[$];
  int                n_checks;
  int                n_errors;
  logic              done;

  data_memory #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .DataAddress (DataAddress),
    .ReadMem     (ReadMem),
    .WriteMem    (WriteMem),
    .DataIn      (DataIn),
    .DataOut     (DataOut)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: compares DataOut against the head of the scoreboard queue.
  always @(negedge clk) begin
    if (obs_valid) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL scoreboard_empty: DataOut=%02h with no expectation queued", DataOut);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        n_checks++;
        if (DataOut !== e.exp) begin
          n_errors++;
          $display("FAIL %s: DataOut=%02h expected=%02h", e.name, DataOut, e.exp);
        end
      end
    end
  end

  // Queue an expectation for the current input setup; the monitor samples it
  // on the next falling edge, then the task returns just after the rising edge.
  task automatic expect_out(input string name, input byte_t exp);
    exp_t e;
    e.name = name;
    e.exp  = exp;
    sb_q.push_back(e);
    obs_valid = 1'b1;
    @(posedge clk);
    #1;
    obs_valid = 1'b0;
  endtask

  task automatic drive(input logic rst, input logic rd, input logic wr,
                       input logic [ADDR_W-1:0] addr, input byte_t din);
    reset       = rst;
    ReadMem     = rd;
    WriteMem    = wr;
    DataAddress = addr;
    DataIn      = din;
  endtask

  // Watchdog so the run can never hang.
  initial begin
    #100000;
    if (!done) begin
      $display("FAIL watchdog: simulation did not complete, time=%0t", $time);
      $fatal(1, "watchdog expired");
    end
  end

  // Directed stimulus.
  initial begin
    n_checks  = 0;
    n_errors  = 0;
    done      = 1'b0;
    obs_valid = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 8'd0, 8'h00);
    @(posedge clk);
    #1;

    // Reset forces DataOut low even with ReadMem high.
    drive(1'b1, 1'b1, 1'b0, 8'd0, 8'h00);
    expect_out("reset_out", 8'h00);

    // Basic write of A5 to addr 9 with ReadMem low, then read back.
    dut.mem_core[8] = 8'h44;
    dut.mem_core[9] = 8'h00;
    drive(1'b0, 1'b0, 1'b1, 8'd9, 8'hA5);
    expect_out("write_rden_low", 8'h00);
    drive(1'b0, 1'b1, 1'b0, 8'd9, 8'h00);
    expect_out("basic_read", 8'hA5);
    drive(1'b0, 1'b1, 1'b0, 8'd8, 8'h00);
    expect_out("addr8_unchanged", 8'h44);

    // Read enable low blanks the output; raising it shows the data again.
    drive(1'b0, 1'b0, 1'b0, 8'd9, 8'h00);
    expect_out("rden_low", 8'h00);
    drive(1'b0, 1'b1, 1'b0, 8'd9, 8'h00);
    expect_out("rden_raise", 8'hA5);

    // Write attempted during reset is dropped; storage survives reset.
    dut.mem_core[11] = 8'h7F;
    drive(1'b1, 1'b1, 1'b1, 8'd11, 8'h3C);
    expect_out("reset_write_out", 8'h00);
    drive(1'b0, 1'b1, 1'b0, 8'd11, 8'h00);
    expect_out("reset_keeps_data", 8'h7F);

    // Read during write: old value before the edge, new value after.
    dut.mem_core[13] = 8'h00;
    drive(1'b0, 1'b1, 1'b1, 8'd13, 8'h5A);
    expect_out("rdw_before", 8'h00);
    drive(1'b0, 1'b1, 1'b0, 8'd13, 8'h00);
    expect_out("rdw_after", 8'h5A);

    // Backdoor preload and boundary addresses.
    dut.mem_core[12]  = 8'h12;
    dut.mem_core[255] = 8'hFF;
    drive(1'b0, 1'b1, 1'b0, 8'd12, 8'h00);
    expect_out("backdoor_12", 8'h12);
    drive(1'b0, 1'b1, 1'b0, 8'd255, 8'h00);
    expect_out("backdoor_255", 8'hFF);

    // Write 01 to addr 0; addr 255 must be untouched.
    dut.mem_core[0] = 8'hEE;
    drive(1'b0, 1'b0, 1'b1, 8'd0, 8'h01);
    expect_out("write_addr0", 8'h00);
    drive(1'b0, 1'b1, 1'b0, 8'd0, 8'h00);
    expect_out("read_addr0", 8'h01);
    drive(1'b0, 1'b1, 1'b0, 8'd255, 8'h00);
    expect_out("addr255_unaffected", 8'hFF);

    // Backdoor update on the selected address is visible without an edge.
    drive(1'b0, 1'b1, 1'b0, 8'd12, 8'h00);
    dut.mem_core[12] = 8'h77;
    expect_out("backdoor_live", 8'h77);

    // Reset blanks the output regardless of address and enables.
    drive(1'b1, 1'b1, 1'b1, 8'd255, 8'h99);
    expect_out("reset_blank_255", 8'h00);
    drive(1'b0, 1'b1, 1'b0, 8'd255, 8'h00);
    expect_out("reset_no_write_255", 8'hFF);

    // Drain: every queued expectation must have been consumed.
    for (int i = 0; i < 10 && sb_q.size() != 0; i++) begin
      @(posedge clk);
    end
    n_checks++;
    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: pending=%0d expected=0", sb_q.size());
    end

    done = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_data_memory
`default_nettype wire

// File: doc/data_memory.md
# data_memory

Byte-addressable 256 × 8 data memory for the single-cycle processor datapath. Single write port on the clock edge, combinational read port. Storage is a hierarchically accessible array, so benches can preload operands and check results by direct backdoor access between program runs. Top level instantiates it with implicit port connections.

## Interface

Parameters:
- DATA_W, 8, word width in bits.
- ADDR_W, 8, address width in bits; depth = 2**ADDR_W = 256.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high.
- DataAddress  input  ADDR_W  byte address for read and write.
- ReadMem  input  1  read enable.
- WriteMem  input  1  write enable.
- DataIn  input  DATA_W  write data.
- DataOut  output  DATA_W  read data.

## Operation

- Storage: unpacked array named exactly `mem_core`, DATA_W bits × 256 entries, indices 0..255.
  - Must remain hierarchically readable and writable as `<inst>.mem_core[i]` and `<inst>.mem_core[i][b:a]`.
  - Never renamed, packed or flattened.
- Write: on a rising clk with reset=0 and WriteMem=1, mem_core[DataAddress] <= DataIn. No other entry changes.
- Read is combinational:
  - DataOut = mem_core[DataAddress] when ReadMem=1 and reset=0.
  - Otherwise DataOut = 0.
- ReadMem and WriteMem may both be 1. Write occurs at the edge; DataOut shows the old value before the edge and the new value after it.
- Reset:
  - Does NOT clear storage. Contents persist across resets so preloaded operands survive.
  - While reset=1, writes are suppressed and DataOut = 0.
- Backdoor writes to mem_core are immediately visible on DataOut when that address is selected and ReadMem=1.
- Power-up contents are undefined (X in simulation). No initialization is performed.
- Address is full-range; every 8-bit value is legal and there is no wrap logic. An address with X/Z bits yields X on DataOut and no defined write.

## Timing

- Write latency: one edge. Data is visible on DataOut in the same cycle after the edge.
- Read latency: zero cycles (combinational from DataAddress, ReadMem, reset).
- Reset value of outputs: DataOut = 0 whenever reset=1, independent of other inputs.
- Reset asserted mid-operation: a write presented in a cycle with reset=1 is dropped. Previously written data is retained.
- No handshake, no busy state, no state machine.

## Structure

- Shared package `mem_pkg`: DATA_W=8, ADDR_W=8, DEPTH=256, and a `byte_t` typedef. Processor and benches import it.
- No sub-modules. Flat array with one clocked write process and one combinational read process.

## Test plan

- Basic write/read:
  - Stimulus: write 8'hA5 to addr 9 (WriteMem=1, one edge), then ReadMem=1, addr 9.
  - Response: DataOut=8'hA5; addr 8 unchanged.
- Read enable low:
  - Stimulus: mem_core[9]=8'hA5, ReadMem=0.
  - Response: DataOut=8'h00. Raise ReadMem → 8'hA5 in the same cycle.
- Reset behaviour:
  - Stimulus: with reset=1, WriteMem=1, addr 11, DataIn=8'h3C for one edge.
  - Response: mem_core[11] keeps its prior value (e.g. 8'h7F); DataOut=0 during reset.
  - After deassert, read addr 11 → 8'h7F (storage not cleared).
- Read during write:
  - Stimulus: mem_core[13]=8'h00, then ReadMem=WriteMem=1, addr 13, DataIn=8'h5A.
  - Response: DataOut=8'h00 before the edge and 8'h5A after it.
- Backdoor and boundary addresses:
  - Stimulus: bench sets mem_core[12]=8'h12 and mem_core[255]=8'hFF hierarchically.
  - Response: reads return 8'h12 and 8'hFF.
  - Also write 8'h01 to addr 0 → addr 0 reads 8'h01 and addr 255 is unaffected.
